// File: rtl/resp_tx_arb.sv
// Arbitrates the UART transmitter between command acks and 16-bit telemetry frames.
// Build option: define TLM_HDR_EN to prefix every telemetry frame with a 0x5A header byte.
//
// state   | meaning
// IDLE    | no byte in flight, arbitrating between ack FIFO and telemetry
// ACK_TX  | ack byte in flight
// TLM_HDR | telemetry header byte in flight (TLM_HDR_EN only)
// TLM_HI  | telemetry high byte in flight
// TLM_LO  | telemetry low byte in flight
module resp_tx_arb #(
  parameter int TMO_CYCLES = 32768,
  parameter int ACK_BURST  = 4,
  parameter int ACK_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  input  logic        tlm_vld,
  input  logic [15:0] tlm_data,
  output logic        tlm_ack,
  input  logic        tx_done,
  output logic        trmt,
  output logic [7:0]  tx_data,
  output logic        ack_ovf,
  output logic        tx_err,
  input  logic        clr_err
);

  localparam int PW = (ACK_DEPTH > 2) ? $clog2(ACK_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
  localparam int BW = $clog2(ACK_BURST + 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TMO_CYCLES - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(ACK_BURST);
  localparam logic [CW-1:0] FIFO_FULL = CW'(ACK_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ACK_TX,
    TLM_HI,
`ifdef TLM_HDR_EN
    TLM_HDR,
`endif
    TLM_LO
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      mem [ACK_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   timer;
  logic [BW-1:0]   burst, burst_nxt;
  logic [15:0]     tlm_word;
  logic            trmt_nxt, tlm_ack_nxt, cap, pop;
  logic [7:0]      tx_data_nxt;
  logic            busy, done_ok, expired, fifo_empty, fifo_full, push_ok, ovf_set;

  assign busy       = (state != IDLE);
  assign done_ok    = busy && !trmt && tx_done;
  assign expired    = busy && !done_ok && (timer == '0);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FIFO_FULL);
  assign push_ok    = send_resp && (!fifo_full || pop);
  assign ovf_set    = send_resp && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    trmt_nxt    = 1'b0;
    tlm_ack_nxt = 1'b0;
    tx_data_nxt = tx_data;
    burst_nxt   = burst;
    cap         = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && (!tlm_vld || burst < BURST_MAX)) begin
          pop         = 1'b1;
          tx_data_nxt = mem[rd_ptr];
          trmt_nxt    = 1'b1;
          burst_nxt   = tlm_vld ? burst + BW'(1) : '0;
          state_nxt   = ACK_TX;
        end else if (tlm_vld) begin
          cap         = 1'b1;
          tlm_ack_nxt = 1'b1;
          trmt_nxt    = 1'b1;
          burst_nxt   = '0;
`ifdef TLM_HDR_EN
          tx_data_nxt = 8'h5A;
          state_nxt   = TLM_HDR;
`else
          tx_data_nxt = tlm_data[15:8];
          state_nxt   = TLM_HI;
`endif
        end
      end
      ACK_TX: if (done_ok) state_nxt = IDLE;
`ifdef TLM_HDR_EN
      TLM_HDR: if (done_ok) begin
        tx_data_nxt = tlm_word[15:8];
        trmt_nxt    = 1'b1;
        state_nxt   = TLM_HI;
      end
`endif
      TLM_HI: if (done_ok) begin
        tx_data_nxt = tlm_word[7:0];
        trmt_nxt    = 1'b1;
        state_nxt   = TLM_LO;
      end
      TLM_LO: if (done_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A lost byte drops whatever is left of the current item
    if (expired) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trmt     <= 1'b0;
      tx_data  <= 8'h00;
      tlm_ack  <= 1'b0;
      ack_ovf  <= 1'b0;
      tx_err   <= 1'b0;
      timer    <= '0;
      burst    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tlm_word <= '0;
    end else begin
      trmt    <= trmt_nxt;
      tx_data <= tx_data_nxt;
      tlm_ack <= tlm_ack_nxt;
      burst   <= burst_nxt;
      ack_ovf <= ovf_set | (ack_ovf & ~clr_err);
      tx_err  <= expired | (tx_err & ~clr_err);
      if (cap) tlm_word <= tlm_data;
      if (trmt_nxt)                 timer <= TMO_LOAD;
      else if (busy && timer != '0) timer <= timer - TW'(1);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= resp;
  end

endmodule

// File: doc/resp_tx_arb.md
Name: resp_tx_arb

Overview:
- Shares the single UART transmitter between two requesters:
  - command-acknowledge responses from the command configuration block (send_resp/resp);
  - 16-bit telemetry words from the flight-status path.
- Buffers ack pulses, serializes telemetry into bytes, sequences the transmitter's trmt/tx_done handshake, and guards against a hung transmitter with a timeout.
- Sits between the command block, the telemetry source and the UART transmitter in the remote-link wrapper.

Parameters:
- TMO_CYCLES, 32768: cycles after trmt without tx_done before the byte is declared lost.
- ACK_BURST, 4: consecutive acks granted while telemetry waits before telemetry is forced a grant.
- ACK_DEPTH, 2: ack FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- send_resp  in  1  single-cycle ack request
- resp  in  8  ack byte, valid with send_resp
- tlm_vld  in  1  telemetry word pending (level, held until tlm_ack)
- tlm_data  in  16  telemetry word
- tlm_ack  out  1  one-cycle pulse: tlm_data captured
- tx_done  in  1  one-cycle pulse: transmitter finished byte
- trmt  out  1  one-cycle pulse: start byte transmission
- tx_data  out  8  byte to transmit, stable from trmt until tx_done
- ack_ovf  out  1  sticky: ack dropped because FIFO full
- tx_err  out  1  sticky: transmit timeout occurred
- clr_err  in  1  clears ack_ovf and tx_err

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset (sync, also mid-operation):
  - state=IDLE; FIFO empty; timer=0; burst count=0;
  - trmt=0, tx_data=0x00, tlm_ack=0, ack_ovf=0, tx_err=0;
  - an in-flight byte is abandoned; a tx_done arriving afterward is ignored.
- Ack FIFO:
  - send_resp pushes resp at the clock edge.
  - Push while full with no pop that cycle: byte dropped, ack_ovf←1.
  - Push and pop in the same cycle while full: both succeed.
- States: IDLE, ACK_TX, TLM_HI, TLM_LO.
- IDLE grant, evaluated each cycle:
  - FIFO non-empty and (tlm_vld=0 or burst<ACK_BURST): pop head into tx_data, trmt=1 next cycle, →ACK_TX, burst+1 if tlm_vld else burst←0.
  - Else if tlm_vld: capture tlm_data, tlm_ack pulse, tx_data←tlm_data[15:8], trmt=1, →TLM_HI, burst←0.
- ACK_TX: on tx_done →IDLE.
- TLM_HI: on tx_done, tx_data←captured[7:0], trmt pulse next cycle, →TLM_LO.
- TLM_LO: on tx_done →IDLE.
  - Telemetry frames are atomic; no ack is interleaved between the hi and lo bytes.
- Latency:
  - send_resp at edge k in IDLE with empty FIFO and no telemetry: trmt high in the cycle after edge k+1 (2 clocks).
  - Between bytes of a frame: trmt exactly 1 cycle after tx_done.
- Timeout:
  - Timer clears on each trmt and counts while waiting for tx_done.
  - At TMO_CYCLES-1 with no tx_done: tx_err←1, the current item (remaining telemetry bytes included) is discarded, →IDLE.
  - tx_done in the same cycle as the timeout counts as success.
- tx_done in IDLE is ignored.
- clr_err in the same cycle as a new error: the error wins (flag remains 1).
- trmt is never high in two consecutive cycles.

Optional Feature:
- Macro TLM_HDR_EN.
- Defined: adds state TLM_HDR ahead of TLM_HI. Each telemetry frame is 0x5A, hi, lo (3 bytes, atomic). tlm_ack timing is unchanged.
- Undefined: 2-byte frames, no header state.

Test Plan:
- Reset, then send_resp with resp=0xA5 → trmt 2 clocks later with tx_data=0xA5; tx_done returns the block to IDLE; ack_ovf=0.
- tlm_vld with tlm_data=0x12C4 → tlm_ack one pulse; bytes 0x12 then 0xC4, each trmt 1 cycle after the prior tx_done (with TLM_HDR_EN: 0x5A,0x12,0xC4).
- Three send_resp pulses (0x01,0x02,0x03) while the transmitter is busy on a telemetry byte, ACK_DEPTH=2 → 0x03 dropped, ack_ovf=1, later 0x01,0x02 sent in order; clr_err → ack_ovf=0.
- tlm_vld held high and 6 acks queued back-to-back, ACK_BURST=4 → order ack×4, telemetry frame, remaining acks.
- trmt issued, tx_done withheld for TMO_CYCLES → tx_err=1, lo byte not sent, next pending ack sent normally.
- rst asserted in TLM_LO, then stray tx_done → all outputs reset, no trmt, FIFO empty.
